// File: rtl/am2940_sequencer.sv
// Purpose : programs an AM2940 DMA address generator from one descriptor per job and paces its stepping.
// Latency : descriptor accepted at edge T; WRITE_CR/LOAD_ADDR/LOAD_WC occupy T+1..T+3; RUN from T+4; one FIN cycle.
// Backpr. : desc_ready is high only in IDLE; xfer_req is acked combinationally in RUN unless done/abort/timeout.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   desc_valid/desc_ready        descriptor handshake; desc_addr/desc_count/desc_mode payload
//   xfer_req/xfer_ack            memory-side word step request and same-cycle grant
//   abort                        cancels the current job (ignored in IDLE)
//   busy/dma_done/dma_err        job status: in progress, one-cycle completion, sticky error
//   am_i/am_datain/am_aci/am_wci AM2940 instruction, data and carry-in pins
//   am_done                      AM2940 done output
module am2940_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [WIDTH-1:0] desc_addr,
  input  logic [WIDTH-1:0] desc_count,
  input  logic [2:0]       desc_mode,
  input  logic             xfer_req,
  output logic             xfer_ack,
  input  logic             abort,
  output logic             busy,
  output logic             dma_done,
  output logic             dma_err,
  output logic [2:0]       am_i,
  output logic [WIDTH-1:0] am_datain,
  output logic             am_aci,
  output logic             am_wci,
  input  logic             am_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CR   = 3'd1,
    S_LD_ADDR = 3'd2,
    S_LD_WC   = 3'd3,
    S_RUN     = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [2:0] I_WRITE_CR   = 3'd0;
  localparam logic [2:0] I_READ_AC    = 3'd3;
  localparam logic [2:0] I_LOAD_ADDR  = 3'd5;
  localparam logic [2:0] I_LOAD_WC    = 3'd6;
  localparam logic [2:0] I_ENABLE_CNT = 3'd7;

  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] WDOG_ONE  = TW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [2:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic [TW-1:0]    wdog_q, wdog_d;

  logic [TW-1:0]    wdog_inc;
  logic             timeout_hit;

  // The watchdog fires on the RUN cycle that would bring the idle count up to
  // TIMEOUT, so exactly TIMEOUT request-free RUN cycles elapse before exit.
  assign wdog_inc    = wdog_q + WDOG_ONE;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_RUN) && !xfer_req &&
                       (wdog_inc == TIMEOUT_C);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    mode_d     = mode_q;
    err_d      = err_q;
    wdog_d     = '0;
    desc_ready = 1'b0;
    busy       = 1'b1;
    xfer_ack   = 1'b0;
    dma_done   = 1'b0;
    am_i       = I_READ_AC;
    am_datain  = '0;

    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        desc_ready = 1'b1;
        if (desc_valid) begin
          addr_d  = desc_addr;
          count_d = desc_count;
          mode_d  = desc_mode;
          err_d   = 1'b0;
          state_d = S_WR_CR;
        end
      end
      S_WR_CR: begin
        am_i      = I_WRITE_CR;
        am_datain = WIDTH'(mode_q);
        state_d   = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        am_i      = I_LOAD_ADDR;
        am_datain = addr_q;
        state_d   = S_LD_WC;
      end
      S_LD_WC: begin
        am_i      = I_LOAD_WC;
        am_datain = count_q;
        // A zero-length job never enables counting.
        state_d   = (count_q == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        am_i   = I_ENABLE_CNT;
        wdog_d = xfer_req ? '0 : wdog_inc;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (am_done) begin
          // Counter already exhausted: a concurrent request is not granted.
          state_d = S_FIN;
        end else if (xfer_req) begin
          xfer_ack = 1'b1;
        end
      end
      S_FIN: begin
        dma_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including a pending completion.
    if ((state_q != S_IDLE) && abort) begin
      state_d  = S_IDLE;
      err_d    = 1'b1;
      xfer_ack = 1'b0;
      dma_done = 1'b0;
    end
  end

  // Both AM2940 counters step together on every granted word.
  assign am_aci  = xfer_ack;
  assign am_wci  = xfer_ack;
  assign dma_err = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_am2940_sequencer.sv
// Purpose : self-checking bench for am2940_sequencer with a behavioural AM2940 word counter.
// Latency : expected AM2940 programming, acks and completion are queued per job and matched as they appear.
// Backpr. : descriptors are offered only while the sequencer is idle; requests follow per-job patterns.
module tb_am2940_sequencer;

  localparam int W = 8;

  localparam int EV_PROG = 1;
  localparam int EV_ACK  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic [W-1:0] desc_addr = '0;
  logic [W-1:0] desc_count = '0;
  logic [2:0]   desc_mode = '0;
  logic         xfer_req = 1'b0;
  logic         xfer_ack;
  logic         abort = 1'b0;
  logic         busy;
  logic         dma_done;
  logic         dma_err;
  logic [2:0]   am_i;
  logic [W-1:0] am_datain;
  logic         am_aci;
  logic         am_wci;
  logic         am_done;

  int  n_chk = 0;
  int  n_err = 0;
  int  run_cycles = 0;
  int  rc;
  ev_t exp_q[$];
  bit  pat_q[$];

  // Behavioural AM2940 word counter: loaded by LOAD_WC, decremented by wci
  // under ENABLE_CNT, done while counting with the counter at zero.
  logic [W-1:0] wc_m = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (am_i == 3'd6)                     wc_m <= am_datain;
    else if ((am_i == 3'd7) && am_wci)    wc_m <= wc_m - 8'd1;
  end
  assign am_done = (am_i == 3'd7) && (wc_m == '0);

  am2940_sequencer #(.WIDTH(W), .TIMEOUT(4), .TW(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_count (desc_count),
    .desc_mode  (desc_mode),
    .xfer_req   (xfer_req),
    .xfer_ack   (xfer_ack),
    .abort      (abort),
    .busy       (busy),
    .dma_done   (dma_done),
    .dma_err    (dma_err),
    .am_i       (am_i),
    .am_datain  (am_datain),
    .am_aci     (am_aci),
    .am_wci     (am_wci),
    .am_done    (am_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input int a, input int c, input int m);
    push_ev(EV_PROG, (0 << 8) | m);
    push_ev(EV_PROG, (5 << 8) | a);
    push_ev(EV_PROG, (6 << 8) | c);
  endtask

  task automatic sb_pop(input string tag, input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_kind"}, kind, e.kind);
      chk({tag, "_val"}, val, e.val);
    end
  endtask

  // Called once per cycle, well after the falling edge, with inputs settled.
  task automatic monitor();
    if (busy && ((am_i == 3'd0) || (am_i == 3'd5) || (am_i == 3'd6)))
      sb_pop("prog", EV_PROG, int'({am_i, am_datain}));
    if (xfer_ack || am_aci || am_wci)
      sb_pop("ack", EV_ACK, int'({xfer_ack, am_aci, am_wci}));
    if (dma_done)
      sb_pop("done", EV_DONE, 1);
    if (am_i == 3'd7)
      run_cycles++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      xfer_req = 1'b0;
      abort    = 1'b0;
      #1;
      monitor();
    end
  endtask

  // Offers one descriptor from IDLE and steps until completion or an early exit.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] c, input logic [2:0] m,
                         input bit hold_req, input bit use_abort, input logic [2:0] abort_i,
                         output int rcyc);
    int base;
    int k;
    bit fin;
    base = run_cycles;
    k    = 0;
    fin  = 1'b0;
    @(negedge clk);
    desc_addr  = a;
    desc_count = c;
    desc_mode  = m;
    desc_valid = 1'b1;
    #1;
    monitor();
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      if (am_i == 3'd7) begin
        xfer_req = (k < pat_q.size()) ? pat_q[k] : hold_req;
        k++;
      end else begin
        xfer_req = hold_req;
      end
      abort = use_abort && busy && (am_i == abort_i);
      #1;
      monitor();
      if (dma_done || !busy) fin = 1'b1;
    end
    if (!fin) chk("job_end_seen", 0, 1);
    rcyc = run_cycles - base;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_am_i", am_i, 3);
    chk("rst_am_datain", am_datain, 0);
    chk("rst_am_aci", am_aci, 0);
    chk("rst_am_wci", am_wci, 0);
    chk("rst_xfer_ack", xfer_ack, 0);
    chk("rst_dma_done", dma_done, 0);
    chk("rst_dma_err", dma_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Normal job, requests held high
    push_prog(8'h40, 3, 3'b001);
    repeat (3) push_ev(EV_ACK, 7);
    push_ev(EV_DONE, 1);
    pat_q.delete();
    run_job(8'h40, 8'd3, 3'b001, 1'b1, 1'b0, 3'd0, rc);
    chk("norm_run_cycles", rc, 4);
    idle(1);
    chk("norm_desc_ready", desc_ready, 1);
    chk("norm_busy", busy, 0);
    chk("norm_err", dma_err, 0);
    chk("norm_sb_empty", exp_q.size(), 0);

    // Zero count: no counting phase at all
    push_prog(8'h11, 0, 3'b101);
    push_ev(EV_DONE, 1);
    run_job(8'h11, 8'd0, 3'b101, 1'b1, 1'b0, 3'd0, rc);
    chk("zero_run_cycles", rc, 0);
    idle(1);
    chk("zero_sb_empty", exp_q.size(), 0);

    // Gapped requests; trailing request coincides with am_done and is refused
    push_prog(8'h80, 3, 3'b010);
    repeat (3) push_ev(EV_ACK, 7);
    push_ev(EV_DONE, 1);
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job(8'h80, 8'd3, 3'b010, 1'b1, 1'b0, 3'd0, rc);
    pat_q.delete();
    chk("gap_run_cycles", rc, 7);
    idle(1);
    chk("gap_sb_empty", exp_q.size(), 0);

    // Abort while loading the address
    push_ev(EV_PROG, (0 << 8) | 3);
    push_ev(EV_PROG, (5 << 8) | 8'h22);
    run_job(8'h22, 8'd4, 3'b011, 1'b1, 1'b1, 3'd5, rc);
    chk("abort_busy", busy, 0);
    chk("abort_err", dma_err, 1);
    chk("abort_desc_ready", desc_ready, 1);
    idle(3);
    chk("abort_err_sticky", dma_err, 1);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Next accepted descriptor clears the error
    push_prog(8'h05, 2, 3'b100);
    repeat (2) push_ev(EV_ACK, 7);
    push_ev(EV_DONE, 1);
    run_job(8'h05, 8'd2, 3'b100, 1'b1, 1'b0, 3'd0, rc);
    chk("clr_err", dma_err, 0);
    idle(1);
    chk("clr_sb_empty", exp_q.size(), 0);

    // Watchdog: no requests in RUN for TIMEOUT cycles
    push_prog(8'h33, 5, 3'b000);
    run_job(8'h33, 8'd5, 3'b000, 1'b0, 1'b0, 3'd0, rc);
    chk("tmo_run_cycles", rc, 4);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", dma_err, 1);
    idle(3);
    chk("tmo_sb_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    desc_addr  = 8'h70;
    desc_count = 8'd10;
    desc_mode  = 3'b001;
    desc_valid = 1'b1;
    xfer_req   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      if (am_i == 3'd7) break;
    end
    @(negedge clk);
    #1;
    chk("pre_rst_aci", am_aci, 1);
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_am_i", am_i, 3);
    chk("mid_rst_aci", am_aci, 0);
    chk("mid_rst_desc_ready", desc_ready, 1);
    chk("mid_rst_err", dma_err, 0);
    xfer_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
